// File: rtl/bist_pkg.sv
// Shared constants for the per-scan BIST datapath: FSM encoding, LFSR taps and seed.
// The LFSR step helper is kept here so the generator and any future checker agree on the polynomial.
package bist_pkg;

    localparam int SIGNATURE_BITS = 16;
    localparam logic [SIGNATURE_BITS-1:0] DEFAULT_SEED = 16'hACE1;

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form, shifting toward the MSB
    localparam int LFSR_TAP_A = 15;
    localparam int LFSR_TAP_B = 13;
    localparam int LFSR_TAP_C = 12;
    localparam int LFSR_TAP_D = 10;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_SHIFT   = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_UNLOAD  = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_CLEAR   = ST_CLEAR,
        S_SHIFT   = ST_SHIFT,
        S_CAPTURE = ST_CAPTURE,
        S_UNLOAD  = ST_UNLOAD,
        S_DONE    = ST_DONE
    } bist_state_e;

    function automatic logic [SIGNATURE_BITS-1:0] lfsr_step(input logic [SIGNATURE_BITS-1:0] l);
        logic fb;
        fb = l[LFSR_TAP_A] ^ l[LFSR_TAP_B] ^ l[LFSR_TAP_C] ^ l[LFSR_TAP_D];
        return {l[SIGNATURE_BITS-2:0], fb};
    endfunction

endpackage

// File: rtl/bist_pattern_gen_lfsr16.sv
// 16-bit Fibonacci LFSR supplying scan stimulus; reset or load restores the seed,
// otherwise it steps only when asked and holds in between.
module lfsr16
    import bist_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      load,
    input  logic [SIGNATURE_BITS-1:0] seed,
    input  logic                      advance,
    output logic [SIGNATURE_BITS-1:0] state
);

    logic [SIGNATURE_BITS-1:0] r_state;

    always_ff @(posedge clock) begin
        if (reset || load) begin
            r_state <= seed;
        end else if (advance) begin
            r_state <= lfsr_step(r_state);
        end
    end

    assign state = r_state;

endmodule

// File: rtl/bist_pattern_gen.sv
// BIST scan sequencer: shifts LFSR stimulus into the CUT chain, pulses capture and
// steers the MISR so each response is compacted while the next pattern shifts in.
module bist_pattern_gen
    import bist_pkg::*;
#(
    parameter int                        CHAIN_LENGTH  = 8,
    parameter int                        PATTERN_COUNT = 4,
    parameter logic [SIGNATURE_BITS-1:0] SEED          = DEFAULT_SEED
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    output logic                               scan_in,
    output logic                               scan_en,
    output logic                               misr_clear,
    output logic                               misr_enable,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(PATTERN_COUNT+1)-1:0] pattern_index,
    output logic [SIGNATURE_BITS-1:0]          lfsr_state
);

    localparam int BIT_W = $clog2(CHAIN_LENGTH);
    localparam int PAT_W = $clog2(PATTERN_COUNT + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LENGTH - 1);
    localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(PATTERN_COUNT - 1);

    bist_state_e               r_state;
    bist_state_e               w_state_nxt;
    logic [BIT_W-1:0]          r_bit_cnt;
    logic [BIT_W-1:0]          w_bit_cnt_nxt;
    logic [PAT_W-1:0]          r_pat_cnt;
    logic [PAT_W-1:0]          w_pat_cnt_nxt;
    logic                      w_lfsr_load;
    logic                      w_lfsr_adv;
    logic [SIGNATURE_BITS-1:0] w_lfsr;

    lfsr16 u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .load    (w_lfsr_load),
        .seed    (SEED),
        .advance (w_lfsr_adv),
        .state   (w_lfsr)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_pat_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_pat_cnt <= w_pat_cnt_nxt;
        end
    end

    // start only steers the next state and the LFSR reload; every output below
    // decodes from registered state and counters.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_pat_cnt_nxt = r_pat_cnt;
        w_lfsr_load   = 1'b0;
        w_lfsr_adv    = 1'b0;
        scan_in       = 1'b0;
        scan_en       = 1'b0;
        misr_clear    = 1'b0;
        misr_enable   = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_lfsr_load = 1'b1;
                if (start) begin
                    w_state_nxt   = S_CLEAR;
                    w_bit_cnt_nxt = '0;
                    w_pat_cnt_nxt = '0;
                end
            end
            S_CLEAR: begin
                misr_clear  = 1'b1;
                busy        = 1'b1;
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                scan_en     = 1'b1;
                scan_in     = w_lfsr[SIGNATURE_BITS-1];
                misr_enable = (r_pat_cnt != '0);
                busy        = 1'b1;
                w_lfsr_adv  = 1'b1;
                if (r_bit_cnt == BIT_LAST) begin
                    w_state_nxt   = S_CAPTURE;
                    w_bit_cnt_nxt = '0;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            S_CAPTURE: begin
                busy          = 1'b1;
                w_pat_cnt_nxt = r_pat_cnt + 1'b1;
                if (r_pat_cnt == PAT_LAST) begin
                    w_state_nxt = S_UNLOAD;
                end else begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_UNLOAD: begin
                // Flushes the final response into the MISR with zero fill.
                scan_en     = 1'b1;
                misr_enable = 1'b1;
                busy        = 1'b1;
                if (r_bit_cnt == BIT_LAST) begin
                    w_state_nxt   = S_DONE;
                    w_bit_cnt_nxt = '0;
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_state_nxt   = S_CLEAR;
                    w_bit_cnt_nxt = '0;
                    w_pat_cnt_nxt = '0;
                    w_lfsr_load   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign pattern_index = r_pat_cnt;
    assign lfsr_state    = w_lfsr;

endmodule
